gf180mcu_fd_sc_mcu9t5v0__skidbuf_2: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__skidbuf_2.sv | 98 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__skidbuf_2.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__skidbuf_2.sv
// Two-entry registered skid buffer (valid/ready repeater); all outputs decode flops only.
// Latency: 1 cycle forward, full throughput. Backpressure: I_RDY drops only when both M and S hold data.
// Optional OCC occupancy output when GF180MCU_FD_SC_MCU9T5V0_SKIDBUF_OCC_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__skidbuf_2 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VLD,
  output logic             I_RDY,
  output logic [WIDTH-1:0] Z,
  output logic             Z_VLD,
  input  logic             Z_RDY,
  inout  wire              VDD,
  inout  wire              VSS
`ifdef GF180MCU_FD_SC_MCU9T5V0_SKIDBUF_OCC_EN
  ,
  output logic [1:0]       OCC
`endif
);

  // Encoding doubles as the stored-word count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] s;
  logic             load_m;
  logic             load_s;
  logic             m_from_s;
  logic             in_xfer;
  logic             out_xfer;
  wire              unused_pwr;

  assign unused_pwr = VDD ^ VSS;

  assign Z_VLD    = (state != EMPTY);
  assign I_RDY    = (state != TWO);
  assign Z        = m;
  assign in_xfer  = I_VLD & I_RDY;
  assign out_xfer = Z_VLD & Z_RDY;

`ifdef GF180MCU_FD_SC_MCU9T5V0_SKIDBUF_OCC_EN
  assign OCC = state;
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Ternaries rather than if/else so an X on a handshake input reaches the state.
  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    case (state)
      EMPTY: begin
        state_nxt = in_xfer ? ONE : EMPTY;
        load_m    = in_xfer;
      end
      ONE: begin
        state_nxt = (in_xfer & ~out_xfer) ? TWO :
                    (~in_xfer & out_xfer) ? EMPTY : ONE;
        load_m    = in_xfer & out_xfer;
        load_s    = in_xfer & ~out_xfer;
      end
      TWO: begin
        state_nxt = out_xfer ? ONE : TWO;
        m_from_s  = out_xfer;
      end
      default: begin
        state_nxt = state_t'('x);
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      m <= '0;
      s <= '0;
    end else begin
      m <= load_m ? I : (m_from_s ? s : m);
      s <= load_s ? I : s;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__skidbuf_2.sv
// Bench for the two-entry skid buffer: directed table, reset/stream sequences, random traffic at widths 1/8/64.
module tb_gf180mcu_fd_sc_mcu9t5v0__skidbuf_2;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;

  always #5 clk = ~clk;

  logic [7:0]  i8   = '0;
  logic        ivld8 = 1'b0, zrdy8 = 1'b0, irdy8, zvld8;
  logic [7:0]  z8;
  logic [0:0]  i1   = '0;
  logic        ivld1 = 1'b0, zrdy1 = 1'b0, irdy1, zvld1;
  logic [0:0]  z1;
  logic [63:0] i64  = '0;
  logic        ivld64 = 1'b0, zrdy64 = 1'b0, irdy64, zvld64;
  logic [63:0] z64;
  logic [1:0]  occ8, occ1, occ64;

`ifdef GF180MCU_FD_SC_MCU9T5V0_SKIDBUF_OCC_EN
  gf180mcu_fd_sc_mcu9t5v0__skidbuf_2 #(.WIDTH(8)) u8 (
    .CLK(clk), .RN(rn), .I(i8), .I_VLD(ivld8), .I_RDY(irdy8), .Z(z8), .Z_VLD(zvld8),
    .Z_RDY(zrdy8), .VDD(vdd), .VSS(vss), .OCC(occ8));
  gf180mcu_fd_sc_mcu9t5v0__skidbuf_2 #(.WIDTH(1)) u1 (
    .CLK(clk), .RN(rn), .I(i1), .I_VLD(ivld1), .I_RDY(irdy1), .Z(z1), .Z_VLD(zvld1),
    .Z_RDY(zrdy1), .VDD(vdd), .VSS(vss), .OCC(occ1));
  gf180mcu_fd_sc_mcu9t5v0__skidbuf_2 #(.WIDTH(64)) u64 (
    .CLK(clk), .RN(rn), .I(i64), .I_VLD(ivld64), .I_RDY(irdy64), .Z(z64), .Z_VLD(zvld64),
    .Z_RDY(zrdy64), .VDD(vdd), .VSS(vss), .OCC(occ64));
`else
  gf180mcu_fd_sc_mcu9t5v0__skidbuf_2 #(.WIDTH(8)) u8 (
    .CLK(clk), .RN(rn), .I(i8), .I_VLD(ivld8), .I_RDY(irdy8), .Z(z8), .Z_VLD(zvld8),
    .Z_RDY(zrdy8), .VDD(vdd), .VSS(vss));
  gf180mcu_fd_sc_mcu9t5v0__skidbuf_2 #(.WIDTH(1)) u1 (
    .CLK(clk), .RN(rn), .I(i1), .I_VLD(ivld1), .I_RDY(irdy1), .Z(z1), .Z_VLD(zvld1),
    .Z_RDY(zrdy1), .VDD(vdd), .VSS(vss));
  gf180mcu_fd_sc_mcu9t5v0__skidbuf_2 #(.WIDTH(64)) u64 (
    .CLK(clk), .RN(rn), .I(i64), .I_VLD(ivld64), .I_RDY(irdy64), .Z(z64), .Z_VLD(zvld64),
    .Z_RDY(zrdy64), .VDD(vdd), .VSS(vss));
  assign occ8  = 2'd0;
  assign occ1  = 2'd0;
  assign occ64 = 2'd0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of capacity two; occupancy is the queue depth.
  logic [7:0]  q8[$];
  logic [0:0]  q1[$];
  logic [63:0] q64[$];

  always @(negedge clk) if (rn) begin
    check("zvld8_model", 64'(zvld8), 64'(q8.size() != 0));
    check("irdy8_model", 64'(irdy8), 64'(q8.size() < 2));
`ifdef GF180MCU_FD_SC_MCU9T5V0_SKIDBUF_OCC_EN
    check("occ8_model", 64'(occ8), 64'(q8.size()));
    check("occ8_flags", 64'(occ8), 64'(zvld8) + 64'(~irdy8));
`endif
    if (zvld8 && zrdy8) begin
      if (q8.size() == 0) check("sb8_underflow", 64'(1), 64'(0));
      else check("sb8_data", 64'(z8), 64'(q8.pop_front()));
    end
    if (ivld8 && irdy8) q8.push_back(i8);
  end

  always @(negedge clk) if (rn) begin
    check("zvld1_model", 64'(zvld1), 64'(q1.size() != 0));
    check("irdy1_model", 64'(irdy1), 64'(q1.size() < 2));
    if (zvld1 && zrdy1) begin
      if (q1.size() == 0) check("sb1_underflow", 64'(1), 64'(0));
      else check("sb1_data", 64'(z1), 64'(q1.pop_front()));
    end
    if (ivld1 && irdy1) q1.push_back(i1);
  end

  always @(negedge clk) if (rn) begin
    check("zvld64_model", 64'(zvld64), 64'(q64.size() != 0));
    check("irdy64_model", 64'(irdy64), 64'(q64.size() < 2));
    if (zvld64 && zrdy64) begin
      if (q64.size() == 0) check("sb64_underflow", 64'(1), 64'(0));
      else check("sb64_data", z64, q64.pop_front());
    end
    if (ivld64 && irdy64) q64.push_back(i64);
  end

  typedef struct {
    logic       ivld;
    logic [7:0] i;
    logic       zrdy;
    logic       zvld;
    logic       irdy;
    logic [7:0] z;
    logic [1:0] occ;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Fill, block third word, hold, drain, then stream through ONE and empty.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 2'd2};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11, 2'd2};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 2'd2};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 2'd0};
    tbl[6] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 2'd1};
    tbl[7] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 2'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 2'd0};

    #3;
    check("rst_z", 64'(z8), 64'(0));
    check("rst_zvld", 64'(zvld8), 64'(0));
    check("rst_irdy", 64'(irdy8), 64'(1));
    step();
    step();
    rn = 1'b1;

    // Streaming with downstream always ready.
    zrdy8 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      ivld8 = 1'b1;
      i8    = 8'(k);
      step();
      check("stream_z", 64'(z8), 64'(k));
      check("stream_zvld", 64'(zvld8), 64'(1));
      check("stream_irdy", 64'(irdy8), 64'(1));
    end
    ivld8 = 1'b0;
    step();
    check("stream_empty", 64'(zvld8), 64'(0));

    for (int r = 0; r < 10; r++) begin
      ivld8 = tbl[r].ivld;
      i8    = tbl[r].i;
      zrdy8 = tbl[r].zrdy;
      step();
      check($sformatf("tbl%0d_zvld", r), 64'(zvld8), 64'(tbl[r].zvld));
      check($sformatf("tbl%0d_irdy", r), 64'(irdy8), 64'(tbl[r].irdy));
      check($sformatf("tbl%0d_z", r), 64'(z8), 64'(tbl[r].z));
`ifdef GF180MCU_FD_SC_MCU9T5V0_SKIDBUF_OCC_EN
      check($sformatf("tbl%0d_occ", r), 64'(occ8), 64'(tbl[r].occ));
`endif
    end

    // Asynchronous reset while full, checked without any clock edge.
    zrdy8 = 1'b0;
    ivld8 = 1'b1;
    i8    = 8'h66;
    step();
    i8 = 8'h77;
    step();
    check("pre_rst_irdy", 64'(irdy8), 64'(0));
    rn = 1'b0;
    q8.delete();
    q1.delete();
    q64.delete();
    #1;
    check("arst_z", 64'(z8), 64'(0));
    check("arst_zvld", 64'(zvld8), 64'(0));
    check("arst_irdy", 64'(irdy8), 64'(1));
`ifdef GF180MCU_FD_SC_MCU9T5V0_SKIDBUF_OCC_EN
    check("arst_occ", 64'(occ8), 64'(0));
`endif
    #1;
    rn    = 1'b1;
    ivld8 = 1'b1;
    i8    = 8'hA5;
    step();
    check("post_rst_z", 64'(z8), 64'hA5);
    check("post_rst_zvld", 64'(zvld8), 64'(1));
    ivld8 = 1'b0;
    zrdy8 = 1'b1;
    step();
    check("post_rst_drain", 64'(zvld8), 64'(0));

    // Random handshakes on all three widths; the monitors carry the checks.
    for (int c = 0; c < 10000; c++) begin
      ivld8  = 1'($urandom_range(1));
      zrdy8  = 1'($urandom_range(1));
      i8     = 8'($urandom);
      ivld1  = 1'($urandom_range(1));
      zrdy1  = 1'($urandom_range(1));
      i1     = 1'($urandom);
      ivld64 = 1'($urandom_range(1));
      zrdy64 = 1'($urandom_range(1));
      i64    = {$urandom, $urandom};
      step();
    end
    ivld8  = 1'b0;
    ivld1  = 1'b0;
    ivld64 = 1'b0;
    zrdy8  = 1'b1;
    zrdy1  = 1'b1;
    zrdy64 = 1'b1;
    repeat (4) step();
    check("q8_drained", 64'(q8.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    check("q64_drained", 64'(q64.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
